// File: rtl/neuron_mac_sequencer.sv
// Dot-product sequencer for one neuron: fetches x/w pairs, feeds the shared
// multiplier and accumulates products onto a bias with sign-magnitude saturation.
module neuron_mac_sequencer #(
  parameter int N_MAX  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [31:0]       bias,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic              ovf,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       x_data,
  input  logic [31:0]       w_data,
  output logic [31:0]       mul_a,
  output logic [31:0]       mul_b,
  input  logic [31:0]       mul_c
);
  typedef enum logic [2:0] {IDLE, READ, LOAD, ACC, DONE} state_t;

  localparam logic [ADDR_W:0] N_MAX_L = (ADDR_W+1)'(N_MAX);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  state_t            state_reg, state_next;
  logic [31:0]       acc_reg, result_reg, mul_a_reg, mul_b_reg;
  logic [ADDR_W:0]   idx_reg, n_reg, len_clamped;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic              ovf_reg, last_elem, sum_ovf;
  logic [31:0]       sum;

  // Returns {overflow, value}; -0 inputs behave as +0 and a zero result is always +0.
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic        sa, sb;
    logic [30:0] ma, mb;
    logic [31:0] mag_sum;
    logic [32:0] r;
    ma = a[30:0];
    mb = b[30:0];
    sa = a[31] & (ma != '0);
    sb = b[31] & (mb != '0);
    mag_sum = {1'b0, ma} + {1'b0, mb};
    if (sa == sb) begin
      if (mag_sum[31])
        r = {1'b1, sa, 31'h7FFF_FFFF};
      else
        r = {1'b0, sa & (mag_sum != '0), mag_sum[30:0]};
    end else if (ma >= mb) begin
      r = {1'b0, sa & (ma != mb), ma - mb};
    end else begin
      r = {1'b0, sb, mb - ma};
    end
    return r;
  endfunction

  assign {sum_ovf, sum} = sat_add(acc_reg, mul_c);
  assign len_clamped    = (len > N_MAX_L) ? N_MAX_L : len;
  assign last_elem      = (idx_reg == n_reg - ONE_L);

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    rd_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = (len_clamped == '0) ? DONE : READ;
      end
      READ: begin
        rd_en      = 1'b1;
        state_next = LOAD;
      end
      LOAD: state_next = ACC;
      ACC:  state_next = last_elem ? DONE : READ;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg     <= '0;
      result_reg  <= '0;
      mul_a_reg   <= '0;
      mul_b_reg   <= '0;
      idx_reg     <= '0;
      n_reg       <= '0;
      ovf_reg     <= 1'b0;
      rd_addr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          acc_reg <= bias;
          idx_reg <= '0;
          ovf_reg <= 1'b0;
          n_reg   <= len_clamped;
          if (len_clamped == '0) result_reg <= bias;
        end
        READ: rd_addr_reg <= idx_reg[ADDR_W-1:0];
        LOAD: begin
          mul_a_reg <= x_data;
          mul_b_reg <= w_data;
        end
        ACC: begin
          acc_reg <= sum;
          idx_reg <= idx_reg + ONE_L;
          if (sum_ovf)   ovf_reg    <= 1'b1;
          if (last_elem) result_reg <= sum;
        end
        default: ;
      endcase
    end
  end

  // rd_addr follows idx while reading and otherwise holds the last address issued.
  assign rd_addr = rd_en ? idx_reg[ADDR_W-1:0] : rd_addr_reg;
  assign result  = result_reg;
  assign ovf     = ovf_reg;
  assign mul_a   = mul_a_reg;
  assign mul_b   = mul_b_reg;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Scoreboard bench for neuron_mac_sequencer: buffer and multiplier models,
// an arithmetic reference for each dot product, and a done-driven monitor.
module tb_neuron_mac_sequencer;
  localparam int ADDR_W = 6;
  localparam longint MAXM = 64'h7FFF_FFFF;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          n;
    int          cyc;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [ADDR_W:0] len = '0;
  logic [31:0] bias = '0;
  logic busy, done, ovf, rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0] result, mul_a, mul_b, mul_c;
  logic [31:0] x_data = '0, w_data = '0;
  logic [31:0] x_mem [64];
  logic [31:0] w_mem [64];

  int n_vec = 0, n_err = 0, cyc = 0, rd_cnt = 0;
  bit chk_idle = 1'b0;
  exp_t exp_q[$];

  neuron_mac_sequencer #(.N_MAX(64), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bias(bias),
    .busy(busy), .done(done), .result(result), .ovf(ovf),
    .rd_en(rd_en), .rd_addr(rd_addr), .x_data(x_data), .w_data(w_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Layer buffers: registered read, data valid the cycle after rd_en.
  always @(posedge clk) if (rd_en) begin
    x_data <= x_mem[rd_addr];
    w_data <= w_mem[rd_addr];
  end

  function automatic longint to_int(input logic [31:0] v);
    longint m;
    m = longint'(v[30:0]);
    return v[31] ? -m : m;
  endfunction

  function automatic logic [31:0] from_int(input longint s);
    logic [63:0] t;
    if (s < 0) begin
      t = -s;
      return {1'b1, t[30:0]};
    end
    t = s;
    return {1'b0, t[30:0]};
  endfunction

  // Q14.17 sign-magnitude multiplier, truncating and saturating the magnitude.
  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = ({33'b0, a[30:0]} * {33'b0, b[30:0]}) >> 17;
    if (p > 64'h7FFF_FFFF) p = 64'h7FFF_FFFF;
    if (p == 64'd0) return 32'h0;
    return {a[31] ^ b[31], p[30:0]};
  endfunction

  always_comb mul_c = mul_model(mul_a, mul_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] r;
    logic [30:0] m;
    r = $urandom;
    m = ($urandom_range(0, 3) == 0) ? 31'h7FFF_FFFF : 31'h0007_FFFF;
    r[30:0] = r[30:0] & m;
    return r;
  endfunction

  // Monitor: address sequence on every read, scoreboard pop on every done.
  always @(negedge clk) begin
    exp_t e;
    if (chk_idle) begin
      chk("busy_after_done", busy, 0);
      chk_idle = 1'b0;
    end
    if (rst_n && rd_en) begin
      chk("rd_addr", rd_addr, rd_cnt);
      rd_cnt++;
    end
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        $display("txn n=%0d result=%h ovf=%b cyc=%0d", e.n, result, ovf, cyc);
        chk("result", result, e.res);
        chk("ovf", ovf, e.ovf);
        chk("done_cycle", cyc, e.cyc);
        chk("read_count", rd_cnt, e.n);
        chk("busy_at_done", busy, 1);
      end
      rd_cnt   = 0;
      chk_idle = 1'b1;
    end
  end

  task automatic wait_done(input bit glitch);
    int cnt;
    cnt = 0;
    while (!done && cnt < 400) begin
      @(negedge clk);
      cnt++;
      if (glitch && cnt == 3) begin start = 1'b1; len = 7'd5; end
      if (glitch && cnt == 4) start = 1'b0;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input int l, input logic [31:0] b, input bit glitch);
    exp_t   e;
    longint acc;
    bit     o;
    int     n;
    n   = (l > 64) ? 64 : l;
    acc = to_int(b);
    o   = 1'b0;
    for (int k = 0; k < n; k++) begin
      acc += to_int(mul_model(x_mem[k], w_mem[k]));
      if (acc > MAXM)       begin acc = MAXM;  o = 1'b1; end
      else if (acc < -MAXM) begin acc = -MAXM; o = 1'b1; end
    end
    e.res = (n == 0) ? b : from_int(acc);
    e.ovf = o;
    e.n   = n;
    @(negedge clk);
    e.cyc = cyc + 1 + 3 * n;
    exp_q.push_back(e);
    start = 1'b1;
    len   = l[ADDR_W:0];
    bias  = b;
    @(negedge clk);
    start = 1'b0;
    len   = 7'($urandom);
    bias  = $urandom;
    wait_done(glitch);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l;
    for (int k = 0; k < 64; k++) begin x_mem[k] = '0; w_mem[k] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);    chk("rst_ovf", ovf, 0);
    chk("rst_result", result, 0);  chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);    chk("rst_rd_addr", rd_addr, 0);
    rst_n = 1'b1;

    x_mem[0] = 32'h0006_487E; w_mem[0] = 32'h0002_0000;
    run_op(1, 32'h0, 1'b0);
    chk("single_const", result, 32'h0006_487E);

    x_mem[0] = 32'h0002_0000; x_mem[1] = 32'h0002_0000; x_mem[2] = 32'h0002_0000;
    w_mem[0] = 32'h0002_0000; w_mem[1] = 32'h0004_0000; w_mem[2] = 32'h8001_0000;
    run_op(3, 32'h0002_0000, 1'b1);
    chk("mixed_const", result, 32'h0007_0000);

    x_mem[0] = 32'h0002_0000; w_mem[0] = 32'h8002_0000;
    run_op(1, 32'h0002_0000, 1'b0);
    chk("cancel_const", result, 32'h0);
    x_mem[0] = 32'h0;
    run_op(1, 32'h8000_0000, 1'b0);
    chk("neg_zero_const", result, 32'h0);

    x_mem[0] = 32'h0002_0000; x_mem[1] = 32'h0002_0000;
    w_mem[0] = 32'h0004_0000; w_mem[1] = 32'h0004_0000;
    run_op(2, 32'h7FFF_0000, 1'b0);
    chk("sat_pos_const", result, 32'h7FFF_FFFF);
    w_mem[0] = 32'h8004_0000; w_mem[1] = 32'h8004_0000;
    run_op(2, 32'hFFFF_0000, 1'b0);
    chk("sat_neg_const", result, 32'hFFFF_FFFF);
    chk("sat_neg_ovf", ovf, 1);
    run_op(0, 32'h1234_5678, 1'b0);
    chk("ovf_cleared", ovf, 0);

    for (int k = 0; k < 64; k++) begin x_mem[k] = rnd_val(); w_mem[k] = rnd_val(); end
    run_op(100, rnd_val(), 1'b0);

    // Abort a len=3 run with reset in cycle 5.
    @(negedge clk);
    start = 1'b1; len = 7'd3; bias = 32'h0002_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);     chk("abort_done", done, 0);
    chk("abort_rd_en", rd_en, 0);   chk("abort_ovf", ovf, 0);
    chk("abort_result", result, 0); chk("abort_mul_a", mul_a, 0);
    chk("abort_mul_b", mul_b, 0);   chk("abort_rd_addr", rd_addr, 0);
    rd_cnt = 0;
    rst_n  = 1'b1;
    run_op(3, 32'h0002_0000, 1'b0);

    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < 64; k++) begin x_mem[k] = rnd_val(); w_mem[k] = rnd_val(); end
      case ($urandom_range(0, 9))
        0:       l = 0;
        1:       l = $urandom_range(60, 127);
        default: l = $urandom_range(1, 8);
      endcase
      run_op(l, rnd_val(), 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
